// File: rtl/layer_mac_scheduler.sv
// Time-multiplexed fully connected layer: one shared MAC walks NEURONS neurons of
// INPUTS inputs each, reading weights/biases from a synchronous ROM and streaming ReLU'd results.
module layer_mac_scheduler #(
    parameter int INPUTS  = 15,
    parameter int NEURONS = 32,
    parameter int DW      = 16,
    parameter int AW      = 10,
    parameter int SHIFT   = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [INPUTS*DW-1:0]   in_vec,
    output logic                   w_rd_en,
    output logic [AW-1:0]          w_addr,
    input  logic signed [DW-1:0]   w_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DW-1:0]          out_data,
    output logic [9:0]             out_idx,
    output logic                   out_last,
    output logic                   busy,
    output logic                   done
);
    localparam int ACCW = 2*DW + 8;
    localparam int KW   = $clog2(INPUTS + 2);

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_BIAS, S_OUT, S_DONE} state_t;

    state_t                 state_q, state_d;
    logic [KW-1:0]          k_q, k_d;
    logic [9:0]             n_q, n_d;
    logic [AW-1:0]          addr_q, addr_d;
    logic signed [ACCW-1:0] acc_q, acc_d;
    logic [DW-1:0]          out_q, out_d;
    logic signed [DW-1:0]   act_q [INPUTS];
    logic signed [DW-1:0]   act_d [INPUTS];

    logic signed [2*DW-1:0] prod;
    logic signed [ACCW-1:0] acc_shifted;
    logic signed [ACCW:0]   biased;
    logic                   neg;
    logic                   over;

    // The activation buffer rotates once per MAC, so act_q[0] is always the
    // activation paired with the ROM word returning this cycle.
    assign prod        = act_q[0] * w_data;
    assign acc_shifted = acc_q >>> SHIFT;
    assign biased      = {acc_shifted[ACCW-1], acc_shifted}
                       + {{(ACCW+1-DW){w_data[DW-1]}}, w_data};
    assign neg         = biased[ACCW] || (biased == '0);
    assign over        = !biased[ACCW] && (|biased[ACCW-1:DW-1]);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            n_q     <= '0;
            addr_q  <= '0;
            acc_q   <= '0;
            out_q   <= '0;
            for (int i = 0; i < INPUTS; i++) begin
                act_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            n_q     <= n_d;
            addr_q  <= addr_d;
            acc_q   <= acc_d;
            out_q   <= out_d;
            act_q   <= act_d;
        end
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        n_d     = n_q;
        addr_d  = addr_q;
        acc_d   = acc_q;
        out_d   = out_q;
        act_d   = act_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    for (int i = 0; i < INPUTS; i++) begin
                        act_d[i] = in_vec[i*DW +: DW];
                    end
                    k_d     = '0;
                    n_d     = '0;
                    addr_d  = '0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                // Read k is issued now; the word for read k-1 arrives now.
                if (k_q == '0) begin
                    acc_d = '0;
                end else begin
                    acc_d = acc_q + {{(ACCW-2*DW){prod[2*DW-1]}}, prod};
                    for (int i = 0; i < INPUTS-1; i++) begin
                        act_d[i] = act_q[i+1];
                    end
                    act_d[INPUTS-1] = act_q[0];
                end
                if (k_q == KW'(INPUTS)) begin
                    state_d = S_BIAS;
                end else begin
                    k_d    = k_q + 1'b1;
                    addr_d = addr_q + 1'b1;
                end
            end
            S_BIAS: begin
                out_d   = neg  ? '0 :
                          over ? {1'b0, {(DW-1){1'b1}}} : biased[DW-1:0];
                state_d = S_OUT;
            end
            S_OUT: begin
                if (out_ready) begin
                    if (n_q == 10'(NEURONS-1)) begin
                        state_d = S_DONE;
                    end else begin
                        n_d     = n_q + 1'b1;
                        k_d     = '0;
                        addr_d  = addr_q + 1'b1;
                        state_d = S_FETCH;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign w_rd_en   = (state_q == S_FETCH);
    assign w_addr    = addr_q;
    assign out_valid = (state_q == S_OUT);
    assign out_data  = out_q;
    assign out_idx   = n_q;
    assign out_last  = (state_q == S_OUT) && (n_q == 10'(NEURONS-1));
    assign done      = (state_q == S_DONE);
endmodule

// File: tb/tb_layer_mac_scheduler.sv
// Self-checking bench for layer_mac_scheduler: a behavioural ROM plus an
// arithmetic per-neuron reference model, driven by scenario tasks.
module tb_layer_mac_scheduler;
    localparam int INPUTS  = 15;
    localparam int NEURONS = 32;
    localparam int DW      = 16;
    localparam int AW      = 10;
    localparam int SHIFT   = 0;
    localparam int LAT     = INPUTS + 3;
    localparam int LIMIT   = 20000;

    logic                  clk = 1'b0;
    logic                  reset, in_valid, in_ready, w_rd_en;
    logic                  out_valid, out_ready, out_last, busy, done;
    logic [INPUTS*DW-1:0]  in_vec;
    logic [AW-1:0]         w_addr;
    logic signed [DW-1:0]  w_data;
    logic [DW-1:0]         out_data;
    logic [9:0]            out_idx;

    logic signed [DW-1:0]  rom [2**AW];

    int compared   = 0;
    int mismatched = 0;
    int resData[$], resIdx[$], resLast[$], resStart[$], resHs[$], addrLog[$];
    int firstValid, doneAt, doneCount, readsInOut, holdErrs;
    bit timedOut;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (w_rd_en) w_data <= rom[w_addr];
    end

    layer_mac_scheduler #(
        .INPUTS(INPUTS), .NEURONS(NEURONS), .DW(DW), .AW(AW), .SHIFT(SHIFT)
    ) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_vec(in_vec), .w_rd_en(w_rd_en), .w_addr(w_addr), .w_data(w_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_idx(out_idx), .out_last(out_last), .busy(busy), .done(done)
    );

    // Dot product of the whole vector with neuron n's ROM row, then bias, ReLU, clamp.
    function automatic int model(int n, logic [INPUTS*DW-1:0] v);
        longint s = 0;
        logic signed [DW-1:0] a;
        for (int k = 0; k < INPUTS; k++) begin
            a = v[k*DW +: DW];
            s += longint'(a) * longint'(rom[n*(INPUTS+1)+k]);
        end
        s = (s >>> SHIFT) + longint'(rom[n*(INPUTS+1)+INPUTS]);
        if (s <= 0) return 0;
        if (s > longint'((1 << (DW-1)) - 1)) return (1 << (DW-1)) - 1;
        return int'(s);
    endfunction

    function automatic logic [INPUTS*DW-1:0] mkVec(int lo, int hi);
        logic [INPUTS*DW-1:0] v;
        for (int k = 0; k < INPUTS; k++) begin
            v[k*DW +: DW] = DW'(lo + int'($urandom_range(hi - lo)));
        end
        return v;
    endfunction

    task automatic fillRom(int wlo, int whi, int blo, int bhi);
        for (int n = 0; n < NEURONS; n++) begin
            for (int k = 0; k < INPUTS; k++) begin
                rom[n*(INPUTS+1)+k] = DW'(wlo + int'($urandom_range(whi - wlo)));
            end
            rom[n*(INPUTS+1)+INPUTS] = DW'(blo + int'($urandom_range(bhi - blo)));
        end
    endtask

    // Accepts one vector and records every handshake until done or the cycle limit.
    task automatic runVector(input logic [INPUTS*DW-1:0] v, input int stallPct,
                             input int stallIdx, input int stallLen, input bit poke);
        int t, stallLeft, heldData, heldIdx;
        bit waiting;
        resData.delete(); resIdx.delete(); resLast.delete();
        resStart.delete(); resHs.delete(); addrLog.delete();
        firstValid = -1; doneAt = -1; doneCount = 0; readsInOut = 0; holdErrs = 0;
        timedOut = 0; stallLeft = stallLen; waiting = 0; heldData = 0; heldIdx = 0;
        @(negedge clk);
        in_vec = v; in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        in_vec = mkVec(-32768, 32767);
        t = 1;
        while (t < LIMIT) begin
            if (done) begin
                doneAt = t;
                doneCount++;
                break;
            end
            if (w_rd_en) addrLog.push_back(int'(w_addr));
            if (out_valid && w_rd_en) readsInOut++;
            if (out_valid) begin
                if (!waiting) begin
                    if (firstValid < 0) firstValid = t;
                    resStart.push_back(t);
                    heldData = int'(out_data);
                    heldIdx  = int'(out_idx);
                end else if (int'(out_data) != heldData || int'(out_idx) != heldIdx) begin
                    holdErrs++;
                end
            end
            if (out_valid && int'(out_idx) == stallIdx && stallLeft > 0) begin
                out_ready = 1'b0;
                stallLeft--;
            end else begin
                out_ready = ($urandom_range(99) >= stallPct);
            end
            if (poke) begin
                in_valid = ($urandom_range(2) == 0);
                in_vec   = mkVec(-32768, 32767);
            end
            if (out_valid && out_ready) begin
                resData.push_back(int'(out_data));
                resIdx.push_back(int'(out_idx));
                resLast.push_back(int'(out_last));
                resHs.push_back(t);
            end
            waiting = out_valid && !out_ready;
            @(negedge clk);
            t++;
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        if (t >= LIMIT) timedOut = 1;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_vec = '0;
        repeat (3) @(negedge clk);
        compared++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== '0 || out_idx !== '0 ||
            out_last !== 1'b0 || w_rd_en !== 1'b0 || w_addr !== '0 || busy !== 1'b0 ||
            done !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_state: got rdy=%0b ov=%0b od=%0d idx=%0d last=%0b rd=%0b addr=%0d busy=%0b done=%0b required rdy=1 rest 0",
                     in_ready, out_valid, out_data, out_idx, out_last, w_rd_en, w_addr, busy, done);
        end
        reset = 1'b0;
    endtask

    task automatic test_unity();
        logic [INPUTS*DW-1:0] v;
        int bad;
        fillRom(1, 1, 0, 0);
        v = mkVec(1, 1);
        runVector(v, 0, -1, 0, 0);
        compared++;
        if (timedOut) begin mismatched++; $display("[TB] FAIL unity_timeout: got no done, required done"); end
        compared++;
        if (resData.size() != NEURONS) begin
            mismatched++; $display("[TB] FAIL unity_count: got %0d required %0d", resData.size(), NEURONS);
        end
        for (int i = 0; i < resData.size(); i++) begin
            compared++;
            if (resData[i] !== model(i, v) || resIdx[i] !== i || resLast[i] !== int'(i == NEURONS-1)) begin
                mismatched++;
                $display("[TB] FAIL unity_result[%0d]: got data=%0d idx=%0d last=%0d required data=%0d idx=%0d last=%0d",
                         i, resData[i], resIdx[i], resLast[i], model(i, v), i, int'(i == NEURONS-1));
            end
        end
        compared++;
        if (resData.size() == 0 || resData[0] !== 15) begin
            mismatched++; $display("[TB] FAIL unity_value: got %0d required 15", resData.size() ? resData[0] : -1);
        end
        compared++;
        if (firstValid !== LAT) begin
            mismatched++; $display("[TB] FAIL unity_latency: got %0d required %0d", firstValid, LAT);
        end
        compared++;
        if (doneCount !== 1 || doneAt !== NEURONS*LAT+1) begin
            mismatched++; $display("[TB] FAIL unity_done: got count=%0d at=%0d required 1 at %0d", doneCount, doneAt, NEURONS*LAT+1);
        end
        @(negedge clk);
        compared++;
        if (in_ready !== 1'b1 || done !== 1'b0) begin
            mismatched++; $display("[TB] FAIL unity_idle: got rdy=%0b done=%0b required rdy=1 done=0", in_ready, done);
        end
        bad = (addrLog.size() == NEURONS*(INPUTS+1)) ? -1 : -2;
        for (int i = 0; i < addrLog.size(); i++) if (bad == -1 && addrLog[i] != i) bad = i;
        compared++;
        if (bad != -1) begin
            mismatched++; $display("[TB] FAIL unity_addr_seq: got first bad position %0d (len %0d) required none", bad, addrLog.size());
        end
    endtask

    task automatic test_clamps();
        logic [INPUTS*DW-1:0] v;
        int want [3] = '{0, 32767, 0};
        for (int c = 0; c < 3; c++) begin
            if (c == 0) begin fillRom(-1, -1, 5, 5);       v = mkVec(100, 100);   end
            else if (c == 1) begin fillRom(1000, 1000, 0, 0); v = mkVec(1000, 1000); end
            else begin v = mkVec(-1000, -1000); end
            runVector(v, 20, -1, 0, 0);
            compared++;
            if (timedOut || resData.size() != NEURONS) begin
                mismatched++; $display("[TB] FAIL clamp%0d_count: got %0d required %0d", c, resData.size(), NEURONS);
            end
            for (int i = 0; i < resData.size(); i++) begin
                compared++;
                if (resData[i] !== want[c] || resData[i] !== model(i, v) || resIdx[i] !== i) begin
                    mismatched++;
                    $display("[TB] FAIL clamp%0d[%0d]: got data=%0d idx=%0d required data=%0d idx=%0d",
                             c, i, resData[i], resIdx[i], want[c], i);
                end
            end
        end
    endtask

    task automatic test_mixed();
        logic [INPUTS*DW-1:0] v;
        int bad;
        fillRom(-30, 30, -500, 500);
        for (int k = 0; k < INPUTS; k++) begin
            rom[3*(INPUTS+1)+k] = DW'(k + 1);
            v[k*DW +: DW] = DW'(k);
        end
        rom[3*(INPUTS+1)+INPUTS] = -16'sd7;
        runVector(v, 30, -1, 0, 0);
        compared++;
        if (timedOut || resData.size() != NEURONS) begin
            mismatched++; $display("[TB] FAIL mixed_count: got %0d required %0d", resData.size(), NEURONS);
        end
        for (int i = 0; i < resData.size(); i++) begin
            compared++;
            if (resData[i] !== model(i, v) || resIdx[i] !== i) begin
                mismatched++;
                $display("[TB] FAIL mixed[%0d]: got data=%0d idx=%0d required data=%0d idx=%0d",
                         i, resData[i], resIdx[i], model(i, v), i);
            end
        end
        compared++;
        if (resData.size() < 4 || resData[3] !== 1113) begin
            mismatched++; $display("[TB] FAIL mixed_idx3: got %0d required 1113", resData.size() > 3 ? resData[3] : -1);
        end
        bad = (addrLog.size() >= 4*(INPUTS+1)) ? -1 : -2;
        for (int i = 3*(INPUTS+1); i < 4*(INPUTS+1) && i < addrLog.size(); i++) if (bad == -1 && addrLog[i] != i) bad = i;
        compared++;
        if (bad != -1) begin
            mismatched++; $display("[TB] FAIL mixed_addr_n3: got first bad position %0d required addresses 48..63", bad);
        end
    endtask

    task automatic test_backpressure();
        logic [INPUTS*DW-1:0] v;
        fillRom(-50, 50, -2000, 2000);
        v = mkVec(-50, 50);
        runVector(v, 0, 2, 5, 1);
        compared++;
        if (timedOut || resData.size() != NEURONS) begin
            mismatched++; $display("[TB] FAIL bp_count: got %0d required %0d", resData.size(), NEURONS);
        end
        for (int i = 0; i < resData.size(); i++) begin
            compared++;
            if (resData[i] !== model(i, v) || resIdx[i] !== i) begin
                mismatched++;
                $display("[TB] FAIL bp[%0d]: got data=%0d idx=%0d required data=%0d idx=%0d",
                         i, resData[i], resIdx[i], model(i, v), i);
            end
        end
        compared++;
        if (resHs.size() < 4 || resHs[2] - resStart[2] !== 5 || resStart[3] - resHs[2] !== LAT) begin
            mismatched++;
            $display("[TB] FAIL bp_timing: got held=%0d resume=%0d required held=5 resume=%0d",
                     resHs.size() > 3 ? resHs[2] - resStart[2] : -1,
                     resHs.size() > 3 ? resStart[3] - resHs[2] : -1, LAT);
        end
        compared++;
        if (holdErrs !== 0 || readsInOut !== 0) begin
            mismatched++; $display("[TB] FAIL bp_hold: got changes=%0d reads=%0d required 0 and 0", holdErrs, readsInOut);
        end
        @(negedge clk);
        compared++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            mismatched++; $display("[TB] FAIL bp_idle: got rdy=%0b busy=%0b required 1 and 0", in_ready, busy);
        end
    endtask

    task automatic test_random();
        logic [INPUTS*DW-1:0] v;
        for (int r = 0; r < 3; r++) begin
            fillRom(-60, 60, -3000, 3000);
            v = mkVec(-60, 60);
            runVector(v, int'($urandom_range(60)), -1, 0, 1'($urandom_range(1)));
            compared++;
            if (timedOut || resData.size() != NEURONS || doneCount != 1) begin
                mismatched++; $display("[TB] FAIL rand%0d_count: got %0d done=%0d required %0d done=1", r, resData.size(), doneCount, NEURONS);
            end
            for (int i = 0; i < resData.size(); i++) begin
                compared++;
                if (resData[i] !== model(i, v) || resIdx[i] !== i || resLast[i] !== int'(i == NEURONS-1)) begin
                    mismatched++;
                    $display("[TB] FAIL rand%0d[%0d]: got data=%0d idx=%0d last=%0d required data=%0d idx=%0d",
                             r, i, resData[i], resIdx[i], resLast[i], model(i, v), i);
                end
            end
        end
    endtask

    task automatic test_reset_midop();
        logic [INPUTS*DW-1:0] v;
        int t;
        fillRom(-40, 40, -1000, 1000);
        v = mkVec(-40, 40);
        @(negedge clk);
        in_vec = v; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        t = 0;
        while (!(w_rd_en && w_addr == AW'(4*(INPUTS+1)+2)) && t < LIMIT) begin
            @(negedge clk);
            t++;
        end
        compared++;
        if (t >= LIMIT) begin mismatched++; $display("[TB] FAIL abort_reach: got no neuron-4 fetch, required one"); end
        reset = 1'b1;
        @(negedge clk);
        compared++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || w_rd_en !== 1'b0 || out_data !== '0) begin
            mismatched++;
            $display("[TB] FAIL abort_state: got ov=%0b rdy=%0b busy=%0b rd=%0b od=%0d required 0 1 0 0 0",
                     out_valid, in_ready, busy, w_rd_en, out_data);
        end
        reset = 1'b0;
        v = mkVec(-40, 40);
        runVector(v, 10, -1, 0, 0);
        compared++;
        if (timedOut || resData.size() != NEURONS || resIdx[0] !== 0) begin
            mismatched++; $display("[TB] FAIL abort_restart: got %0d results required %0d from idx 0", resData.size(), NEURONS);
        end
        for (int i = 0; i < resData.size(); i++) begin
            compared++;
            if (resData[i] !== model(i, v) || resIdx[i] !== i) begin
                mismatched++;
                $display("[TB] FAIL abort[%0d]: got data=%0d idx=%0d required data=%0d idx=%0d",
                         i, resData[i], resIdx[i], model(i, v), i);
            end
        end
    endtask

    initial begin
        test_reset();
        test_unity();
        test_clamps();
        test_mixed();
        test_backpressure();
        test_random();
        test_reset_midop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/layer_mac_scheduler.md
Name: layer_mac_scheduler

Overview:
- Time-multiplexed controller for one fully connected ECG-network layer: one shared multiply-accumulate unit evaluates NEURONS neurons of INPUTS inputs each, instead of one parallel node per neuron.
- Weights and biases are fetched from an external synchronous weight ROM.
- Each neuron output is bias-added, ReLU'd, saturated and streamed out under valid/ready.
- Sits between the previous layer's activation register and the next layer's input collector.

Parameters:
INPUTS, 15, activations per input vector (1..256)
NEURONS, 32, neurons evaluated per input vector (1..1024)
DW, 16, activation/weight/bias/output width, signed two's complement
AW, 10, weight ROM address width; must satisfy 2^AW >= NEURONS*(INPUTS+1)
SHIFT, 0, arithmetic right shift applied to accumulator before bias add

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
in_valid  in  1  input vector valid
in_ready  out  1  block can accept a vector (high only in IDLE)
in_vec  in  INPUTS*DW  activations; element k at bits [k*DW +: DW]
w_rd_en  out  1  weight ROM read strobe
w_addr  out  AW  ROM address = n*(INPUTS+1)+k; k=INPUTS is neuron n's bias
w_data  in  DW  ROM data, valid the cycle after w_rd_en
out_valid  out  1  neuron result valid
out_ready  in  1  downstream accepts result
out_data  out  DW  ReLU/saturated neuron result
out_idx  out  10  neuron index n of out_data
out_last  out  1  high with out_valid for neuron NEURONS-1
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse after the last result handshake

Behaviour:
- Reset: state IDLE; in_ready=1; out_valid=0, out_data=0, out_idx=0, out_last=0, w_rd_en=0, w_addr=0, busy=0, done=0; accumulator and activation buffer cleared.
- Reset mid-operation aborts immediately; no partial result is emitted.
- IDLE: in_ready=1. When in_valid&in_ready, latch in_vec into the internal buffer, set n=0, go to FETCH.
- in_vec is not sampled again until the next IDLE.
- FETCH: INPUTS+1 consecutive cycles with w_rd_en=1, k=0..INPUTS. Accumulator cleared on the first cycle.
- MAC: the cycle after read k (k<INPUTS), acc += act[k]*w_data.
  - Product is a full 2*DW signed value.
  - acc is 2*DW+8 bits signed, so no overflow occurs for INPUTS<=256.
- Bias: the cycle after read k=INPUTS, compute s = (acc>>>SHIFT) + sign-extended w_data, then:
  - s<=0 gives out_data=0.
  - s>2^(DW-1)-1 gives out_data=2^(DW-1)-1 (32767).
  - Otherwise out_data=s[DW-1:0].
  - Registered; state goes to OUT.
- OUT: out_valid=1, and out_data/out_idx/out_last are held stable until out_ready. No ROM reads occur while waiting.
  - On handshake with n<NEURONS-1: n++, go to FETCH the next cycle.
  - On handshake with n=NEURONS-1: go to DONE.
- DONE: done=1 for one cycle, then IDLE. The next vector can be accepted the cycle after DONE.
- Latency: accept in cycle T leads to first read in T+1, bias data in T+INPUTS+2, out_valid in cycle T+INPUTS+3 (T+18 for defaults).
- Throughput: with out_ready held high, one result every INPUTS+3 cycles. There is no overlap between neurons.
- A full vector with out_ready high takes NEURONS*(INPUTS+3)+2 cycles from accept to in_ready.
- in_valid while busy is ignored; in_ready=0.
- w_addr is don't-care when w_rd_en=0, but holds its last value.
- out_ready high while out_valid=0 has no effect.

Test Plan:
- Unity check, ROM all weights 1, all biases 0, all activations 1: outputs 15 for n=0..31; out_idx 0..31 in order; out_last only on idx 31; done pulses once; first out_valid exactly 18 cycles after accept.
- Negative clamp, activations 100, weights -1 (0xFFFF), bias 5: sum -1495, out_data=0 for every neuron.
- Saturation, activations 1000, weights 1000, bias 0: sum 15,000,000, out_data=32767. Also activations -1000 with weights 1000 gives 0.
- Mixed per-neuron ROM, neuron 3 weights k+1, activations k, bias -7, SHIFT=0: out_data for idx 3 is sum k(k+1) for k=0..14 minus 7 = 1113. Also check the w_addr sequence is 48..63 for neuron 3.
- Backpressure, out_ready low for 5 cycles on neuron 2: out_valid held, out_data/out_idx stable, w_rd_en=0 throughout; resumes at neuron 3 the cycle after handshake. Also in_valid pulsed while busy is ignored.
- Reset asserted during FETCH of neuron 4: next cycle out_valid=0, in_ready=1, busy=0. A new vector then produces correct results starting at idx 0.
